rca_pipe: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor with valid/ready flow control.
//   The WIDTH-bit operands are split into STAGES equal chunks. Each pipeline stage

---
 rtl/rca_pipe_if.sv | 38 +++
 rtl/rca_pipe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rca_pipe_if.sv
// Valid/ready operand and result bus for rca_pipe.
// The out_ovf signal exists only when RCA_PIPE_OVERFLOW_EN is defined.
interface rca_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

`ifdef RCA_PIPE_OVERFLOW_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks, one chunk per stage,
// bubble-collapsing valid/ready flow control. Define RCA_PIPE_OVERFLOW_EN to add the out_ovf output.
module rca_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic       clk,
    input logic       rst_n,
    rca_pipe_if.slave bus
);
    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("rca_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // Subtraction is A + ~B + 1; in_cin only matters in add mode.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff = bus.in_sub | bus.in_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * C;
        localparam int HI = LO + C;

        logic          src_v;
        logic [C-1:0]  src_a;
        logic [C-1:0]  src_b;
        logic          src_c;
        logic [C-1:0]  sum_c;
        logic [C:0]    cy;
        logic [HI-1:0] nxt_s;
        logic          leave;
        logic          ld;
        logic          v_q;
        logic          c_q;
        logic [HI-1:0] s_q;

        always_comb begin
            cy[0] = src_c;
            for (int i = 0; i < C; i++) begin
                sum_c[i] = src_a[i] ^ src_b[i] ^ cy[i];
                cy[i+1]  = (src_a[i] & src_b[i]) | (cy[i] & (src_a[i] ^ src_b[i]));
            end
        end

        if (k == 0) begin : g_src
            assign src_v = bus.in_valid;
            assign src_a = bus.in_a[C-1:0];
            assign src_b = b_eff[C-1:0];
            assign src_c = cin_eff;
            assign nxt_s = sum_c;
        end else begin : g_src
            assign src_v = g_stg[k-1].v_q;
            assign src_a = g_stg[k-1].g_skew.a_q[C-1:0];
            assign src_b = g_stg[k-1].g_skew.b_q[C-1:0];
            assign src_c = g_stg[k-1].c_q;
            assign nxt_s = {sum_c, g_stg[k-1].s_q};
        end

        // A stage may load when empty or when its current beat moves on this edge.
        if (k == STAGES - 1) begin : g_leave
            assign leave = bus.out_ready;
        end else begin : g_leave
            assign leave = g_stg[k+1].ld;
        end

        assign ld = !v_q || leave;

        // NOTE: non-blocking assignments so each stage samples its neighbour's pre-edge value.
        // NOTE: data registers are reset too, so a discarded beat never resurfaces on out_sum.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (ld) begin
                v_q <= src_v;
                if (src_v) begin
                    c_q <= cy[C];
                    s_q <= nxt_s;
                end
            end
        end

        // Skew registers carry the operand bits that later stages have yet to add.
        if (HI < WIDTH) begin : g_skew
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            logic [WIDTH-HI-1:0] nxt_a;
            logic [WIDTH-HI-1:0] nxt_b;

            if (k == 0) begin : g_rest
                assign nxt_a = bus.in_a[WIDTH-1:HI];
                assign nxt_b = b_eff[WIDTH-1:HI];
            end else begin : g_rest
                assign nxt_a = g_stg[k-1].g_skew.a_q[WIDTH-LO-1:C];
                assign nxt_b = g_stg[k-1].g_skew.b_q[WIDTH-LO-1:C];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld && src_v) begin
                    a_q <= nxt_a;
                    b_q <= nxt_b;
                end
            end
        end

`ifdef RCA_PIPE_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (ld && src_v) begin
                    ovf_q <= cy[C] ^ cy[C-1];
                end
            end
        end
`endif
    end

    assign bus.in_ready  = g_stg[0].ld;
    assign bus.out_valid = g_stg[STAGES-1].v_q;
    assign bus.out_sum   = g_stg[STAGES-1].s_q;
    assign bus.out_cout  = g_stg[STAGES-1].c_q;
`ifdef RCA_PIPE_OVERFLOW_EN
    assign bus.out_ovf   = g_stg[STAGES-1].g_ovf.ovf_q;
`endif
endmodule
